hermes_input_buffer: RTL and testbench

//  Receive-side end of the Hermes credit-based link: one instance per router input port.

---
 rtl/hermes_input_buffer_pkg.sv | 6 +
 rtl/hermes_flit_fifo.sv | 33 +++
 rtl/hermes_input_buffer.sv | 63 ++++++
 tb/tb_hermes_input_buffer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hermes_input_buffer_pkg.sv
// hermes_input_buffer_pkg: shared defaults and the input-buffer packet FSM state type
package hermes_input_buffer_pkg;
  localparam int HERMES_FLIT_SIZE = 32;
  localparam int HERMES_BUFFER_SIZE = 8;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_HEADER, S_SIZE, S_PAYLOAD} hermes_buffer_state_t;
endpackage

// File: rtl/hermes_flit_fifo.sv
// hermes_flit_fifo: circular flit store; in clk_i/rst_i/wr/rd/data_i, out data_o (head, comb) and count
module hermes_flit_fifo #(
  parameter int FLIT_SIZE = 32,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [FLIT_SIZE-1:0]         data_i,
  output logic [FLIT_SIZE-1:0]         data_o,
  output logic [$clog2(BUFFER_SIZE):0] count
);
  localparam int AW = $clog2(BUFFER_SIZE);
  logic [FLIT_SIZE-1:0] mem_q [BUFFER_SIZE];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0] count_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < BUFFER_SIZE; i++) mem_q[i] <= '0;
    end else begin
      if (wr) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q <= rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_q <= count_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  assign data_o = rst_i ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/hermes_input_buffer.sv
// hermes_input_buffer: router input port; rx_i/data_i/credit_o link in, req_routing_o/ack_routing_i to switch control, data_av_o/data_o/ack_i/sending_o to crossbar
module hermes_input_buffer
  import hermes_input_buffer_pkg::*;
#(
  parameter int FLIT_SIZE = HERMES_FLIT_SIZE,
  parameter int BUFFER_SIZE = HERMES_BUFFER_SIZE
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic                 credit_o,
  output logic                 req_routing_o,
  input  logic                 ack_routing_i,
  output logic                 data_av_o,
  output logic [FLIT_SIZE-1:0] data_o,
  input  logic                 ack_i,
  output logic                 sending_o
);
  localparam int CW = $clog2(BUFFER_SIZE) + 1;
  hermes_buffer_state_t state_q, state_d;
  logic [FLIT_SIZE-1:0] flit_cnt_q, flit_cnt_d;
  logic [CW-1:0] count;
  logic wr, rd, has;
  hermes_flit_fifo #(.FLIT_SIZE(FLIT_SIZE), .BUFFER_SIZE(BUFFER_SIZE)) u_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .wr(wr), .rd(rd), .data_i(data_i), .data_o(data_o), .count(count)
  );
  assign has = count != '0;
  assign credit_o = (count != CW'(BUFFER_SIZE)) & !rst_i;
  assign wr = rx_i & credit_o;
  assign rd = data_av_o & ack_i;
  assign req_routing_o = (state_q == S_REQ) & !rst_i;
  assign sending_o = (state_q inside {S_HEADER, S_SIZE, S_PAYLOAD}) & !rst_i;
  // the header is guaranteed present in S_HEADER; later flits may still be in flight
  assign data_av_o = ((state_q == S_HEADER) | (sending_o & has)) & !rst_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      flit_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      flit_cnt_q <= flit_cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    flit_cnt_d = flit_cnt_q;
    case (state_q)
      S_IDLE:    state_d = has ? S_REQ : S_IDLE;
      S_REQ:     state_d = ack_routing_i ? S_HEADER : S_REQ;
      S_HEADER:  state_d = rd ? S_SIZE : S_HEADER;
      S_SIZE: if (rd) begin
        flit_cnt_d = data_o;
        state_d = (data_o == '0) ? S_IDLE : S_PAYLOAD;
      end
      S_PAYLOAD: if (rd) begin
        flit_cnt_d = flit_cnt_q - FLIT_SIZE'(1);
        state_d = (flit_cnt_q == FLIT_SIZE'(1)) ? S_IDLE : S_PAYLOAD;
      end
      default:   state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_hermes_input_buffer.sv
module tb_hermes_input_buffer;
  import hermes_input_buffer_pkg::*;
  logic clk_i = 1'b0, rst_i = 1'b1, rx_i = 1'b1, ack_routing_i = 1'b0, ack_i = 1'b0;
  logic [31:0] data_i = 32'hdead, data_o;
  logic credit_o, req_routing_o, data_av_o, sending_o;
  int tests = 0, fails = 0, mcnt = 0;
  logic [31:0] q [$];

  hermes_input_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .data_i(data_i), .credit_o(credit_o),
    .req_routing_o(req_routing_o), .ack_routing_i(ack_routing_i), .data_av_o(data_av_o),
    .data_o(data_o), .ack_i(ack_i), .sending_o(sending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic put(input logic [31:0] d);
    rx_i = 1'b1;
    data_i = d;
    tick();
    rx_i = 1'b0;
  endtask

  task automatic route(input string nm);
    int n = 0;
    while (!req_routing_o && n < 50) begin
      tick();
      n++;
    end
    check({nm, "_req_rise"}, req_routing_o, 1);
    tick();
    check({nm, "_req_hold1"}, req_routing_o, 1);
    tick();
    check({nm, "_req_hold2"}, req_routing_o, 1);
    ack_routing_i = 1'b1;
    tick();
    ack_routing_i = 1'b0;
    check({nm, "_req_fall"}, req_routing_o, 0);
    check({nm, "_hdr_state"}, dut.state_q, S_HEADER);
    check({nm, "_hdr_send"}, sending_o, 1);
  endtask

  always @(negedge clk_i) begin : monitor
    logic acc;
    if (rst_i) begin
      check("rst_credit", credit_o, 0);
      check("rst_req", req_routing_o, 0);
      check("rst_av", data_av_o, 0);
      check("rst_send", sending_o, 0);
      check("rst_data", data_o, 0);
      q.delete();
      mcnt = 0;
    end else begin
      check("credit", credit_o, mcnt != 8);
      acc = rx_i && mcnt != 8;
      if (data_av_o && ack_i) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL underflow: got read of %0h expected no flit available", data_o);
        end else check("data", data_o, q.pop_front());
        mcnt--;
      end
      if (acc) begin
        q.push_back(data_i);
        mcnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    tick();
    tick();
    rst_i = 1'b0;
    rx_i = 1'b0;
    tick();
    check("rst_count", dut.u_fifo.count, 0);
    check("rst_credit_after", credit_o, 1);
    // single packet
    ack_i = 1'b1;
    fork
      begin put(32'h11); put(3); put(32'hA); put(32'hB); put(32'hC); end
      begin
        route("p1");
        for (int i = 0; i < 5; i++) begin
          check("p1_sending", sending_o, 1);
          tick();
        end
        check("p1_send_fall", sending_o, 0);
        check("p1_idle", dut.state_q, S_IDLE);
        check("p1_drained", q.size(), 0);
      end
    join
    // fill past capacity
    ack_i = 1'b0;
    for (int i = 0; i < 10; i++) put(32'h100 + i);
    check("fill_count", dut.u_fifo.count, 8);
    check("fill_credit", credit_o, 0);
    route("fill");
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    check("free_credit", credit_o, 1);
    put(32'h200);
    check("retry_count", dut.u_fifo.count, 8);
    // read and write together at full: write refused
    rx_i = 1'b1;
    data_i = 32'h300;
    ack_i = 1'b1;
    tick();
    check("simul_count", dut.u_fifo.count, 7);
    data_i = 32'h301;
    ack_i = 1'b0;
    tick();
    rx_i = 1'b0;
    check("refill_count", dut.u_fifo.count, 8);
    for (int i = 0; i < 24; i++) begin
      rx_i = 1'b1;
      data_i = 32'h400 + i;
      ack_i = 1'b1;
      tick();
    end
    rx_i = 1'b0;
    n = 0;
    while (mcnt != 0 && n < 40) begin
      tick();
      n++;
    end
    check("wrap_drained", dut.u_fifo.count, 0);
    check("wrap_queue", q.size(), 0);
    check("empty_av", data_av_o, 0);
    check("empty_hold", dut.state_q, S_PAYLOAD);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    // zero-size packet then size-1 packet
    fork
      begin put(32'h22); put(0); put(32'h33); put(1); put(32'h44); end
      begin
        route("z0");
        tick();
        check("z0_size", dut.state_q, S_SIZE);
        tick();
        check("z0_idle", dut.state_q, S_IDLE);
        check("z0_send_fall", sending_o, 0);
        check("z1_req_low", req_routing_o, 0);
        tick();
        check("z1_req_high", req_routing_o, 1);
        route("z1");
        tick();
        check("z1_size", dut.state_q, S_SIZE);
        tick();
        check("z1_payload", dut.state_q, S_PAYLOAD);
        tick();
        check("z1_idle", dut.state_q, S_IDLE);
        check("z1_send_fall", sending_o, 0);
      end
    join
    // reset mid-payload
    fork
      begin put(32'h55); put(4); put(32'hE0); put(32'hE1); put(32'hE2); put(32'hE3); end
      begin
        route("m");
        for (int i = 0; i < 4; i++) tick();
        check("m_payload", dut.state_q, S_PAYLOAD);
        check("m_left", dut.flit_cnt_q, 2);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("m_req", req_routing_o, 0);
        check("m_av", data_av_o, 0);
        check("m_send", sending_o, 0);
        check("m_count", dut.u_fifo.count, 0);
        check("m_state", dut.state_q, S_IDLE);
      end
    join
    fork
      begin put(32'h66); put(0); end
      begin
        route("post");
        tick();
        tick();
        check("post_idle", dut.state_q, S_IDLE);
        check("post_queue", q.size(), 0);
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
